// File: rtl/expr_sched_pkg.sv
// Shared definitions for the expression job scheduler: FSM encoding and
// default sizing constants.
package expr_sched_pkg;

  localparam int DEF_WIDTH   = 32;
  localparam int DEF_N_REQ   = 4;
  localparam int DEF_TIMEOUT = 64;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_ISSUE = 2'd1,
    S_WAIT  = 2'd2,
    S_RESP  = 2'd3
  } sched_state_t;

endpackage

// File: rtl/expr_job_scheduler_rr_arbiter.sv
// Combinational round-robin arbiter: grants the first requester at or after
// ptr, wrapping from N-1 back to 0.
module rr_arbiter #(
  parameter int N     = 4,
  parameter int IDX_W = $clog2(N)
) (
  input  logic [N-1:0]     req,
  input  logic [IDX_W-1:0] ptr,
  output logic [N-1:0]     grant,
  output logic [IDX_W-1:0] grant_idx,
  output logic             any
);

  function automatic logic [IDX_W-1:0] wrap_idx(input logic [IDX_W-1:0] p, input int k);
    int s;
    s = (int'(p) + k) % N;
    return IDX_W'(s);
  endfunction

  always_comb begin
    grant     = '0;
    grant_idx = '0;
    any       = 1'b0;
    for (int k = 0; k < N; k++) begin
      if (!any && req[wrap_idx(ptr, k)]) begin
        any                     = 1'b1;
        grant[wrap_idx(ptr, k)] = 1'b1;
        grant_idx               = wrap_idx(ptr, k);
      end
    end
  end

endmodule

// File: rtl/expr_job_scheduler.sv
// Shares one start/done expression datapath between N_REQ requesters:
// round-robin accept, one job in flight, tagged response, watchdog abort.
module expr_job_scheduler
  import expr_sched_pkg::*;
#(
  parameter int WIDTH    = DEF_WIDTH,
  parameter int OP_WIDTH = WIDTH + 3,
  parameter int N_REQ    = DEF_N_REQ,
  parameter int ID_W     = $clog2(N_REQ),
  parameter int TIMEOUT  = DEF_TIMEOUT
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [N_REQ-1:0]       req_valid,
  output logic [N_REQ-1:0]       req_ready,
  input  logic [N_REQ*WIDTH-1:0] req_a,
  input  logic [N_REQ*WIDTH-1:0] req_b,
  output logic                   dp_start,
  output logic [WIDTH-1:0]       dp_a,
  output logic [WIDTH-1:0]       dp_b,
  input  logic                   dp_done,
  input  logic [OP_WIDTH-1:0]    dp_result,
  output logic                   rsp_valid,
  input  logic                   rsp_ready,
  output logic [ID_W-1:0]        rsp_id,
  output logic [OP_WIDTH-1:0]    rsp_data,
  output logic                   rsp_err,
  output logic [1:0]             dbg_state
);

  localparam int TMR_W = $clog2(TIMEOUT);

  sched_state_t        state_q, state_d;
  logic [ID_W-1:0]     rr_ptr_q, id_q;
  logic [WIDTH-1:0]    a_q, b_q;
  logic [OP_WIDTH-1:0] rsp_data_q;
  logic                rsp_err_q;
  logic [TMR_W-1:0]    timer_q;
  logic [N_REQ-1:0]    arb_grant;
  logic [ID_W-1:0]     arb_idx;
  logic                arb_any;
  logic                timed_out;

  rr_arbiter #(.N(N_REQ), .IDX_W(ID_W)) u_arb (
    .req       (req_valid),
    .ptr       (rr_ptr_q),
    .grant     (arb_grant),
    .grant_idx (arb_idx),
    .any       (arb_any)
  );

  assign timed_out = (timer_q == TMR_W'(TIMEOUT - 1));

  // Handshakes: a request transfers in the cycle req_valid[i] && req_ready[i]
  // (req_ready only asserts in IDLE); a response transfers on
  // rsp_valid && rsp_ready, and rsp_id/data/err stay frozen until then.
  assign req_ready = (state_q == S_IDLE) ? arb_grant : '0;
  assign dp_start  = (state_q == S_ISSUE);
  assign dp_a      = a_q;
  assign dp_b      = b_q;
  assign rsp_valid = (state_q == S_RESP);
  assign rsp_id    = id_q;
  assign rsp_data  = rsp_data_q;
  assign rsp_err   = rsp_err_q;
  assign dbg_state = state_q;

  always_ff @(posedge clk) begin
    if (rst) state_q <= S_IDLE;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:  if (arb_any) state_d = S_ISSUE;
      S_ISSUE: state_d = S_WAIT;
      S_WAIT:  if (dp_done || timed_out) state_d = S_RESP;
      S_RESP:  if (rsp_ready) state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      a_q        <= '0;
      b_q        <= '0;
      id_q       <= '0;
      rr_ptr_q   <= '0;
      rsp_data_q <= '0;
      rsp_err_q  <= 1'b0;
      timer_q    <= '0;
    end else begin
      case (state_q)
        S_IDLE: if (arb_any) begin
          a_q  <= req_a[int'(arb_idx)*WIDTH +: WIDTH];
          b_q  <= req_b[int'(arb_idx)*WIDTH +: WIDTH];
          id_q <= arb_idx;
        end
        S_ISSUE: timer_q <= '0;
        S_WAIT: begin
          // A completion arriving in the final watchdog cycle still counts.
          if (dp_done) begin
            rsp_data_q <= dp_result;
            rsp_err_q  <= 1'b0;
          end else if (timed_out) begin
            rsp_data_q <= '0;
            rsp_err_q  <= 1'b1;
          end else begin
            timer_q <= timer_q + TMR_W'(1);
          end
        end
        S_RESP: if (rsp_ready) begin
          rr_ptr_q <= (id_q == ID_W'(N_REQ - 1)) ? '0 : id_q + ID_W'(1);
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_expr_job_scheduler.sv
// Directed bench for expr_job_scheduler: a stub datapath is driven by hand,
// outputs are sampled on the falling edge.
module tb_expr_job_scheduler;

  localparam int WIDTH = 32;
  localparam int OPW   = 35;
  localparam int NREQ  = 4;

  logic              clk = 1'b0;
  logic              rst = 1'b1;
  logic [NREQ-1:0]   req_valid = '0;
  logic [NREQ-1:0]   req_ready;
  logic [NREQ*WIDTH-1:0] req_a = '0;
  logic [NREQ*WIDTH-1:0] req_b = '0;
  logic              dp_start;
  logic [WIDTH-1:0]  dp_a, dp_b;
  logic              dp_done = 1'b0;
  logic [OPW-1:0]    dp_result = '0;
  logic              rsp_valid;
  logic              rsp_ready = 1'b0;
  logic [1:0]        rsp_id;
  logic [OPW-1:0]    rsp_data;
  logic              rsp_err;
  logic [1:0]        dbg_state;

  int errors = 0;
  int checks = 0;

  expr_job_scheduler dut (
    .clk       (clk),
    .rst       (rst),
    .req_valid (req_valid),
    .req_ready (req_ready),
    .req_a     (req_a),
    .req_b     (req_b),
    .dp_start  (dp_start),
    .dp_a      (dp_a),
    .dp_b      (dp_b),
    .dp_done   (dp_done),
    .dp_result (dp_result),
    .rsp_valid (rsp_valid),
    .rsp_ready (rsp_ready),
    .rsp_id    (rsp_id),
    .rsp_data  (rsp_data),
    .rsp_err   (rsp_err),
    .dbg_state (dbg_state)
  );

  // clock / reset
  always #5 clk = ~clk;

  task automatic step();
    @(negedge clk);
  endtask

  task automatic apply_reset();
    rst = 1'b1; req_valid = '0; dp_done = 1'b0; rsp_ready = 1'b0;
    step();
    rst = 1'b0;
  endtask

  // driver tasks
  task automatic set_ops(input int i, input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b);
    req_a[i*WIDTH +: WIDTH] = a;
    req_b[i*WIDTH +: WIDTH] = b;
  endtask

  task automatic wait_grant(output logic [NREQ-1:0] g, output bit ok);
    ok = 1'b0;
    g  = '0;
    for (int i = 0; i < 16 && !ok; i++) begin
      #1;
      if (req_ready != '0) begin g = req_ready; ok = 1'b1; end
      else step();
    end
  endtask

  // From the accept cycle: pass ISSUE, spend 'delay' extra WAIT cycles, pulse
  // done, and return at the first RESP falling edge.
  task automatic do_job(input logic [OPW-1:0] result, input int delay);
    step();
    step();
    repeat (delay) step();
    dp_done = 1'b1; dp_result = result;
    step();
    dp_done = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1; req_valid = '0;
    step(); step();
    #1;
    checks++; if (dbg_state !== 2'd0) begin errors++; $display("FAIL reset_state: got %0d want 0", dbg_state); end
    checks++; if (req_ready !== 4'b0) begin errors++; $display("FAIL reset_req_ready: got %b want 0000", req_ready); end
    checks++; if (dp_start !== 1'b0) begin errors++; $display("FAIL reset_dp_start: got %b want 0", dp_start); end
    checks++; if (rsp_valid !== 1'b0) begin errors++; $display("FAIL reset_rsp_valid: got %b want 0", rsp_valid); end
    checks++; if ({dp_a, dp_b} !== 64'd0) begin errors++; $display("FAIL reset_dp_ops: got %h want 0", {dp_a, dp_b}); end
    checks++; if ({rsp_id, rsp_data, rsp_err} !== 38'd0) begin errors++; $display("FAIL reset_rsp_fields: got %h want 0", {rsp_id, rsp_data, rsp_err}); end
    rst = 1'b0;
  endtask

  task automatic test_single_job();
    apply_reset();
    set_ops(0, 32'd8, 32'd4);
    req_valid = 4'b0001;
    #1;
    checks++; if (req_ready !== 4'b0001) begin errors++; $display("FAIL single_accept: got %b want 0001", req_ready); end
    step();
    req_valid = '0;
    #1;
    checks++; if (dp_start !== 1'b1) begin errors++; $display("FAIL single_dp_start: got %b want 1", dp_start); end
    checks++; if (dp_a !== 32'd8 || dp_b !== 32'd4) begin errors++; $display("FAIL single_dp_ops: got a=%0d b=%0d want a=8 b=4", dp_a, dp_b); end
    checks++; if (req_ready !== 4'b0) begin errors++; $display("FAIL single_ready_issue: got %b want 0000", req_ready); end
    step();
    checks++; if (dp_start !== 1'b0) begin errors++; $display("FAIL single_start_pulse: got %b want 0", dp_start); end
    checks++; if (dp_a !== 32'd8) begin errors++; $display("FAIL single_dp_a_hold: got %0d want 8", dp_a); end
    repeat (6) step();
    checks++; if (rsp_valid !== 1'b0) begin errors++; $display("FAIL single_early_rsp: got %b want 0", rsp_valid); end
    dp_done = 1'b1; dp_result = 35'd88;
    step();
    dp_done = 1'b0;
    checks++; if (rsp_valid !== 1'b1) begin errors++; $display("FAIL single_rsp_valid: got %b want 1", rsp_valid); end
    checks++; if (rsp_id !== 2'd0) begin errors++; $display("FAIL single_rsp_id: got %0d want 0", rsp_id); end
    checks++; if (rsp_data !== 35'd88) begin errors++; $display("FAIL single_rsp_data: got %0d want 88", rsp_data); end
    checks++; if (rsp_err !== 1'b0) begin errors++; $display("FAIL single_rsp_err: got %b want 0", rsp_err); end
    rsp_ready = 1'b1;
    step();
    checks++; if (rsp_valid !== 1'b0 || dbg_state !== 2'd0) begin errors++; $display("FAIL single_back_idle: got valid=%b state=%0d want 0/0", rsp_valid, dbg_state); end
  endtask

  task automatic test_round_robin();
    logic [NREQ-1:0] g;
    bit ok;
    int exp_id;
    apply_reset();
    for (int i = 0; i < NREQ; i++) set_ops(i, 32'(10 * (i + 1)), 32'(i));
    req_valid = 4'b1111;
    rsp_ready = 1'b1;
    for (int k = 0; k < 5; k++) begin
      exp_id = k % NREQ;
      wait_grant(g, ok);
      checks++; if (!ok || g !== 4'(1 << exp_id)) begin errors++; $display("FAIL rr_grant_%0d: got %b want %b", k, g, 4'(1 << exp_id)); end
      do_job(35'(200 + k), k);
      checks++; if (rsp_id !== 2'(exp_id) || rsp_data !== 35'(200 + k)) begin errors++; $display("FAIL rr_rsp_%0d: got id=%0d data=%0d want id=%0d data=%0d", k, rsp_id, rsp_data, exp_id, 200 + k); end
      step();
    end
    req_valid = '0;
  endtask

  task automatic test_backpressure();
    logic [NREQ-1:0] g;
    bit ok;
    apply_reset();
    set_ops(2, 32'd3, 32'd2);
    req_valid = 4'b0100;
    wait_grant(g, ok);
    checks++; if (!ok || g !== 4'b0100) begin errors++; $display("FAIL bp_grant: got %b want 0100", g); end
    do_job(35'd32, 3);
    req_valid = 4'b0010;
    for (int i = 0; i < 5; i++) begin
      #1;
      checks++; if (rsp_valid !== 1'b1 || rsp_id !== 2'd2 || rsp_data !== 35'd32 || rsp_err !== 1'b0) begin errors++; $display("FAIL bp_hold_%0d: got v=%b id=%0d data=%0d err=%b want 1/2/32/0", i, rsp_valid, rsp_id, rsp_data, rsp_err); end
      checks++; if (req_ready !== 4'b0) begin errors++; $display("FAIL bp_no_accept_%0d: got %b want 0000", i, req_ready); end
      step();
    end
    rsp_ready = 1'b1;
    step();
    #1;
    checks++; if (req_ready !== 4'b0010 || dbg_state !== 2'd0) begin errors++; $display("FAIL bp_next_accept: got ready=%b state=%0d want 0010/0", req_ready, dbg_state); end
    req_valid = '0;
  endtask

  task automatic test_timeout();
    logic [NREQ-1:0] g;
    bit ok;
    apply_reset();
    rsp_ready = 1'b1;
    set_ops(1, 32'd9, 32'd1);
    req_valid = 4'b0010;
    wait_grant(g, ok);
    do_job(35'd123, 2);
    req_valid = '0;
    checks++; if (rsp_data !== 35'd123) begin errors++; $display("FAIL to_prior_data: got %0d want 123", rsp_data); end
    step();
    set_ops(1, 32'd5, 32'd6);
    req_valid = 4'b0010;
    wait_grant(g, ok);
    checks++; if (!ok || g !== 4'b0010) begin errors++; $display("FAIL to_grant: got %b want 0010", g); end
    step();
    req_valid = '0;
    step();
    repeat (63) step();
    checks++; if (rsp_valid !== 1'b0) begin errors++; $display("FAIL to_early: got %b want 0 in last WAIT cycle", rsp_valid); end
    step();
    checks++; if (rsp_valid !== 1'b1 || rsp_err !== 1'b1 || rsp_data !== 35'd0 || rsp_id !== 2'd1) begin errors++; $display("FAIL to_abort: got v=%b err=%b data=%0d id=%0d want 1/1/0/1", rsp_valid, rsp_err, rsp_data, rsp_id); end
    step();
    req_valid = 4'b0010;
    wait_grant(g, ok);
    step();
    req_valid = '0;
    step();
    repeat (63) step();
    dp_done = 1'b1; dp_result = 35'd77;
    step();
    dp_done = 1'b0;
    checks++; if (rsp_valid !== 1'b1 || rsp_err !== 1'b0 || rsp_data !== 35'd77) begin errors++; $display("FAIL to_done_wins: got v=%b err=%b data=%0d want 1/0/77", rsp_valid, rsp_err, rsp_data); end
    step();
  endtask

  task automatic test_reset_mid_job();
    logic [NREQ-1:0] g;
    bit ok;
    apply_reset();
    rsp_ready = 1'b1;
    set_ops(2, 32'd40, 32'd20);
    set_ops(3, 32'd7, 32'd3);
    req_valid = 4'b0100;
    wait_grant(g, ok);
    do_job(35'd555, 1);
    req_valid = 4'b1000;
    step();
    wait_grant(g, ok);
    checks++; if (!ok || g !== 4'b1000) begin errors++; $display("FAIL rm_grant: got %b want 1000", g); end
    step();
    req_valid = '0;
    step(); step();
    rst = 1'b1;
    step();
    rst = 1'b0;
    #1;
    checks++; if (dbg_state !== 2'd0 || dp_start !== 1'b0 || rsp_valid !== 1'b0 || req_ready !== 4'b0) begin errors++; $display("FAIL rm_ctrl_clear: got state=%0d start=%b v=%b ready=%b want 0", dbg_state, dp_start, rsp_valid, req_ready); end
    checks++; if (dp_a !== 32'd0 || dp_b !== 32'd0 || rsp_id !== 2'd0 || rsp_data !== 35'd0 || rsp_err !== 1'b0) begin errors++; $display("FAIL rm_data_clear: got a=%0d b=%0d id=%0d data=%0d err=%b want 0", dp_a, dp_b, rsp_id, rsp_data, rsp_err); end
    dp_done = 1'b1; dp_result = 35'd999;
    step();
    dp_done = 1'b0;
    for (int i = 0; i < 4; i++) begin
      checks++; if (rsp_valid !== 1'b0 || dp_start !== 1'b0) begin errors++; $display("FAIL rm_late_done_%0d: got v=%b start=%b want 0/0", i, rsp_valid, dp_start); end
      step();
    end
    req_valid = 4'b1111;
    #1;
    checks++; if (req_ready !== 4'b0001) begin errors++; $display("FAIL rm_ptr_reset: got %b want 0001", req_ready); end
    req_valid = '0;
    step();
  endtask

  task automatic test_wrap();
    logic [NREQ-1:0] g;
    bit ok;
    apply_reset();
    rsp_ready = 1'b1;
    set_ops(3, 32'd1, 32'd1);
    set_ops(0, 32'd2, 32'd2);
    set_ops(1, 32'd3, 32'd3);
    req_valid = 4'b1000;
    wait_grant(g, ok);
    checks++; if (!ok || g !== 4'b1000) begin errors++; $display("FAIL wrap_grant3: got %b want 1000", g); end
    do_job(35'd11, 0);
    req_valid = 4'b0001;
    checks++; if (rsp_id !== 2'd3 || rsp_data !== 35'd11) begin errors++; $display("FAIL wrap_rsp3: got id=%0d data=%0d want 3/11", rsp_id, rsp_data); end
    step();
    wait_grant(g, ok);
    checks++; if (!ok || g !== 4'b0001) begin errors++; $display("FAIL wrap_grant0: got %b want 0001", g); end
    do_job(35'd22, 1);
    req_valid = 4'b0011;
    checks++; if (rsp_id !== 2'd0 || rsp_data !== 35'd22) begin errors++; $display("FAIL wrap_rsp0: got id=%0d data=%0d want 0/22", rsp_id, rsp_data); end
    step();
    wait_grant(g, ok);
    checks++; if (!ok || g !== 4'b0010) begin errors++; $display("FAIL wrap_ptr1: got %b want 0010", g); end
    req_valid = '0;
    step();
  endtask

  initial begin
    test_reset();
    test_single_job();
    test_round_robin();
    test_backpressure();
    test_timeout();
    test_reset_mid_job();
    test_wrap();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
